// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM state encoding and default parameters for mem_arbiter
package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } state_t;
    localparam int AW_DEF      = 32;
    localparam int DW_DEF      = 32;
    localparam int TIMEOUT_DEF = 15;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store and shared memory port bundle; slave = arbiter side, master = environment side
interface mem_arbiter_if import mem_arbiter_pkg::*; #(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_done;
    logic          i_stall;
    logic          d_rd;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          d_stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          err;
    modport slave (
        input  i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata, mem_ack,
        output i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
               mem_req, mem_we, mem_addr, mem_wdata, err
    );
    modport master (
        output i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata, mem_ack,
        input  i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
               mem_req, mem_we, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/arb_watchdog.sv
// arb_watchdog: access timeout counter, built only with MEM_ARB_TIMEOUT_EN; ports clk, reset, clear, enable -> expire
`ifdef MEM_ARB_TIMEOUT_EN
module arb_watchdog import mem_arbiter_pkg::*; #(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    // fires on the TIMEOUT-th waiting cycle so the abort edge ends exactly that many cycles
    assign expire = enable & (cnt == CW'(TIMEOUT - 1));
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else cnt <= (clear | expire) ? '0 : enable ? cnt + 1'b1 : cnt;
endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch and load/store requests onto one shared memory port
// Ports: clk, reset (async, active-high), bus (mem_arbiter_if.slave: i_* fetch side, d_* data side,
// mem_* shared memory port, err timeout pulse). Optional macro MEM_ARB_TIMEOUT_EN enables the access timeout.
module mem_arbiter import mem_arbiter_pkg::*; #(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic clk,
    input logic reset,
    mem_arbiter_if.slave bus
);
    state_t        state;
    logic          mem_req, mem_we, i_done, d_done, err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, i_rdata, d_rdata;
    logic          d_go, i_go, expire;
    // a requester whose done is high is still showing the request just served, so it is masked;
    // this also hands the fetch the slot right after a data access
    assign d_go = (bus.d_rd | bus.d_wr) & ~d_done;
    assign i_go = bus.i_req & ~i_done;
    assign bus.d_stall   = d_go;
    assign bus.i_stall   = i_go;
    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.i_rdata   = i_rdata;
    assign bus.d_rdata   = d_rdata;
    assign bus.i_done    = i_done;
    assign bus.d_done    = d_done;
    assign bus.err       = err;
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end
`ifdef MEM_ARB_TIMEOUT_EN
    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == IDLE),
        .enable (state != IDLE && !bus.mem_ack),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            err       <= 1'b0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            err    <= 1'b0;
            if (state == IDLE) begin
                if (d_go | i_go) begin
                    state    <= d_go ? DACC : IACC;
                    mem_req  <= 1'b1;
                    mem_we   <= d_go & bus.d_wr;
                    mem_addr <= d_go ? bus.d_addr : bus.i_addr;
                    if (d_go) mem_wdata <= bus.d_wdata;
                end
            end else if (bus.mem_ack | expire) begin
                state   <= IDLE;
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                err     <= expire;
                if (state == DACC) begin
                    d_done <= 1'b1;
                    if (!mem_we) d_rdata <= expire ? '0 : bus.mem_rdata;
                end else begin
                    i_done  <= 1'b1;
                    i_rdata <= expire ? '0 : bus.mem_rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized scoreboard bench for mem_arbiter
module tb_mem_arbiter;
    typedef struct {bit st; logic [31:0] v;} dexp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    mem_arbiter_if #(.AW(32), .DW(32)) bus ();
    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    logic [31:0] iq[$];
    dexp_t dq[$];
    int tests = 0, fails = 0, cyc = 0, last_ack = -10;
    logic [31:0] last_load = '0;
    bit auto_mem = 0;
    logic [31:0] ram_d[64], ref_d[64];
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00500093;
    endfunction
    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, a, e, cyc);
        end
    endtask
    task automatic miss(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: event missing or unexpected at cycle %0d", nm, cyc);
    endtask
    always @(negedge clk) begin
        if (bus.mem_req && bus.mem_ack) last_ack = cyc;
        if (!reset) begin
            chk("i_stall", bus.i_stall, bus.i_req & ~bus.i_done);
            chk("d_stall", bus.d_stall, (bus.d_rd | bus.d_wr) & ~bus.d_done);
            if (bus.i_done) begin
                if (iq.size() == 0) miss("i_done_unexpected");
                else chk("i_rdata", bus.i_rdata, iq.pop_front());
                if (!bus.err) chk("i_latency", cyc, last_ack + 1);
            end
            if (bus.d_done) begin
                if (dq.size() == 0) miss("d_done_unexpected");
                else begin
                    dexp_t e;
                    e = dq.pop_front();
                    if (e.st) chk("d_rdata_after_store", bus.d_rdata, last_load);
                    else begin
                        chk("d_rdata", bus.d_rdata, e.v);
                        last_load = e.v;
                    end
                end
                if (!bus.err) chk("d_latency", cyc, last_ack + 1);
            end
`ifndef MEM_ARB_TIMEOUT_EN
            if (bus.i_done || bus.d_done) chk("err_low", bus.err, 0);
`endif
        end
    end
    // environment memory: random ack delay, stray acks while idle
    int dly;
    bit act = 0;
    always @(posedge clk) begin
        #1;
        if (auto_mem) begin
            bus.mem_ack = 1'b0;
            if (bus.mem_req) begin
                if (!act) begin
                    act = 1;
                    dly = $urandom_range(0, 3);
                    if (bus.mem_addr < 32'h100) begin
                        chk("fetch_addr", bus.mem_addr, bus.i_addr);
                        chk("fetch_we", bus.mem_we, 0);
                    end else begin
                        chk("data_addr", bus.mem_addr, bus.d_addr);
                        chk("data_we", bus.mem_we, bus.d_wr);
                        if (bus.d_wr) chk("data_wdata", bus.mem_wdata, bus.d_wdata);
                    end
                end
                if (dly == 0) begin
                    act = 0;
                    bus.mem_ack = 1'b1;
                    if (bus.mem_addr < 32'h100) bus.mem_rdata = rom(bus.mem_addr);
                    else if (bus.mem_we) begin
                        ram_d[bus.mem_addr[7:2]] = bus.mem_wdata;
                        bus.mem_rdata = $urandom;
                    end else bus.mem_rdata = ram_d[bus.mem_addr[7:2]];
                end else dly--;
            end else if ($urandom_range(0, 7) == 0) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = $urandom;
            end
        end
    end
    task automatic drive_i(input int n);
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            bit got;
            logic [31:0] a;
            if ($urandom_range(0, 2) == 0) begin
                bus.i_req = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            a = 32'($urandom_range(0, 63)) << 2;
            bus.i_req = 1'b1;
            bus.i_addr = a;
            iq.push_back(rom(a));
            got = 0;
            for (int t = 0; t < 100 && !got; t++) begin
                @(negedge clk);
                got = bus.i_done;
            end
            if (!got) miss("i_wait_timeout");
            @(posedge clk); #1;
        end
        bus.i_req = 1'b0;
    endtask
    task automatic drive_d(input int n);
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            bit got;
            int op, idx;
            logic [31:0] w;
            if ($urandom_range(0, 2) == 0) begin
                bus.d_rd = 1'b0;
                bus.d_wr = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            op = $urandom_range(0, 3);
            idx = $urandom_range(0, 63);
            w = $urandom;
            bus.d_rd = (op != 2);
            bus.d_wr = (op >= 2);
            bus.d_addr = 32'h100 + 32'(idx) * 4;
            bus.d_wdata = w;
            if (op >= 2) begin
                ref_d[idx] = w;
                dq.push_back('{1, 32'h0});
            end else dq.push_back('{0, ref_d[idx]});
            got = 0;
            for (int t = 0; t < 100 && !got; t++) begin
                @(negedge clk);
                got = bus.d_done;
            end
            if (!got) miss("d_wait_timeout");
            @(posedge clk); #1;
        end
        bus.d_rd = 1'b0;
        bus.d_wr = 1'b0;
    endtask
    task automatic step;
        @(posedge clk); #1;
    endtask
    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        bus.i_req = 0; bus.i_addr = 0; bus.d_rd = 0; bus.d_wr = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0; bus.mem_ack = 0;
        for (int i = 0; i < 64; i++) begin
            ram_d[i] = $urandom;
            ref_d[i] = ram_d[i];
        end
        repeat (2) step();
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_i_rdata", bus.i_rdata, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        chk("rst_i_done", bus.i_done, 0);
        chk("rst_d_done", bus.d_done, 0);
        chk("rst_err", bus.err, 0);
        reset = 0;
        // fetch only, ack in cycle 1
        step();
        bus.i_req = 1; bus.i_addr = 32'h10; iq.push_back(32'h00500093);
        step();
        chk("f_mem_req", bus.mem_req, 1);
        chk("f_mem_addr", bus.mem_addr, 32'h10);
        bus.mem_ack = 1; bus.mem_rdata = 32'h00500093;
        step();
        bus.mem_ack = 0;
        chk("f_i_done", bus.i_done, 1);
        chk("f_i_rdata", bus.i_rdata, 32'h00500093);
        chk("f_i_stall", bus.i_stall, 0);
        chk("f_mem_req_low", bus.mem_req, 0);
        bus.i_req = 0;
        // contention: data first, then fetch while d_rd is still high
        step();
        bus.i_req = 1; bus.i_addr = 32'h20; bus.d_rd = 1; bus.d_addr = 32'h100;
        iq.push_back(32'h22222222); dq.push_back('{0, 32'h11111111});
        step();
        chk("c_mem_addr_d", bus.mem_addr, 32'h100);
        chk("c_mem_we", bus.mem_we, 0);
        chk("c_i_stall", bus.i_stall, 1);
        bus.mem_ack = 1; bus.mem_rdata = 32'h11111111;
        step();
        bus.mem_ack = 0;
        chk("c_d_done", bus.d_done, 1);
        step();
        chk("c_mem_req_i", bus.mem_req, 1);
        chk("c_mem_addr_i", bus.mem_addr, 32'h20);
        bus.d_rd = 0;
        bus.mem_ack = 1; bus.mem_rdata = 32'h22222222;
        step();
        bus.mem_ack = 0;
        chk("c_i_done", bus.i_done, 1);
        bus.i_req = 0;
        // store held for three cycles before ack
        step();
        bus.d_wr = 1; bus.d_addr = 32'h204; bus.d_wdata = 32'hDEADBEEF; dq.push_back('{1, 32'h0});
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s_mem_we", bus.mem_we, 1);
            chk("s_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
            chk("s_mem_addr", bus.mem_addr, 32'h204);
        end
        bus.mem_ack = 1; bus.mem_rdata = 32'hBADBAD00;
        step();
        bus.mem_ack = 0;
        chk("s_d_done", bus.d_done, 1);
        chk("s_d_rdata_kept", bus.d_rdata, 32'h11111111);
        bus.d_wr = 0;
        // reset in the middle of a load
        step();
        bus.d_rd = 1; bus.d_addr = 32'h108;
        step();
        chk("r_mem_req", bus.mem_req, 1);
        #2 reset = 1;
        #1;
        chk("r_mem_req_low", bus.mem_req, 0);
        chk("r_d_rdata", bus.d_rdata, 0);
        bus.d_rd = 0;
        last_load = '0;
        step();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("r_idle_mem_req", bus.mem_req, 0);
            chk("r_no_d_done", bus.d_done, 0);
        end
        // stray ack while idle
        bus.mem_ack = 1; bus.mem_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("a_mem_req", bus.mem_req, 0);
            chk("a_i_rdata", bus.i_rdata, 0);
            chk("a_i_done", bus.i_done, 0);
        end
        bus.mem_ack = 0;
`ifdef MEM_ARB_TIMEOUT_EN
        begin
            int t;
            step();
            bus.d_rd = 1; bus.d_addr = 32'h10C; dq.push_back('{0, 32'h0});
            for (t = 1; t <= 40; t++) begin
                step();
                if (bus.d_done) break;
            end
            chk("t_cycle", t, 16);
            chk("t_err", bus.err, 1);
            chk("t_mem_req", bus.mem_req, 0);
            bus.d_rd = 0;
        end
`endif
        // randomized concurrent traffic
        step();
        auto_mem = 1;
        fork
            drive_i(80);
            drive_d(80);
        join
        repeat (5) step();
        chk("iq_drained", iq.size(), 0);
        chk("dq_drained", dq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
